// File: rtl/nrx_pkg.sv
// Shared types and constants for the sprite/radar attribute RAM path.
package nrx_pkg;

    localparam int unsigned NRX_SPRAM_ADR_W = 11;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_SPR,
        GNT_CPU
    } gnt_t;

endpackage

// File: rtl/nrx_spram_arbiter.sv
// Shares the 16-bit attribute RAM between the sprite line engine and the Z80 CPU.
// Sprite wins in H-blank, CPU wins in H-display; a bounded-wait counter forces CPU slots.
module nrx_spram_arbiter
    import nrx_pkg::*;
#(
    parameter int unsigned ADR_W    = NRX_SPRAM_ADR_W,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic             VCLKx4,
    input  logic             rst_n,
    input  logic             hblk,
    input  logic             spr_req,
    input  logic [ADR_W-1:0] spr_adr,
    output logic             spr_stall,
    output logic [15:0]      spr_dat,
    output logic             spr_vld,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [ADR_W:0]   cpu_adr,
    input  logic [7:0]       cpu_wd,
    output logic [7:0]       cpu_rd,
    output logic             cpu_wait,
    output logic             cpu_ack,
    output logic [ADR_W-1:0] ram_adr,
    output logic [1:0]       ram_we,
    output logic [15:0]      ram_wd,
    input  logic [15:0]      ram_rd
);

    localparam int unsigned WcntW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WcntW-1:0] WcntMax = WcntW'(MAX_WAIT - 1);

    gnt_t             gnt, gnt_q;
    logic             armed_q, armed_d;
    logic [WcntW-1:0] wcnt_q, wcnt_d;
    logic             lane_q, we_q;
    logic [ADR_W-1:0] adr_q;
    logic             cpu_elig;

    // A CPU grant still returning blocks re-arbitration of the same held request.
    assign cpu_elig = cpu_req & armed_q & (gnt_q != GNT_CPU);

    always_comb begin
        gnt = GNT_NONE;
        if (!rst_n) begin
            gnt = GNT_NONE;
        end else if (cpu_elig && (wcnt_q == WcntMax)) begin
            gnt = GNT_CPU;
        end else if (hblk) begin
            if (spr_req)       gnt = GNT_SPR;
            else if (cpu_elig) gnt = GNT_CPU;
        end else begin
            if (cpu_elig)     gnt = GNT_CPU;
            else if (spr_req) gnt = GNT_SPR;
        end
    end

    always_comb begin
        ram_adr = adr_q;
        ram_we  = 2'b00;
        ram_wd  = 16'h0000;
        unique case (gnt)
            GNT_SPR: ram_adr = spr_adr;
            GNT_CPU: begin
                ram_adr = cpu_adr[ADR_W:1];
                ram_wd  = {cpu_wd, cpu_wd};
                if (cpu_we) ram_we = cpu_adr[0] ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    always_comb begin
        spr_stall = rst_n & spr_req & (gnt != GNT_SPR);
        spr_vld   = rst_n & (gnt_q == GNT_SPR);
        spr_dat   = spr_vld ? ram_rd : 16'h0000;
        cpu_ack   = rst_n & (gnt_q == GNT_CPU);
        cpu_rd    = 8'h00;
        if (cpu_ack && !we_q) cpu_rd = lane_q ? ram_rd[15:8] : ram_rd[7:0];
        cpu_wait  = rst_n & cpu_req & armed_q & ~cpu_ack;
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (!cpu_req || (gnt == GNT_CPU)) begin
            wcnt_d = '0;
        end else if (cpu_elig && (wcnt_q != WcntMax)) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        // Disarm once served; re-arm only after the CPU lets go of the request.
        armed_d = ~cpu_req | (armed_q & (gnt_q != GNT_CPU));
    end

    always_ff @(posedge VCLKx4) begin
        if (!rst_n) begin
            gnt_q   <= GNT_NONE;
            armed_q <= 1'b1;
            wcnt_q  <= '0;
            lane_q  <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
        end else begin
            gnt_q   <= gnt;
            armed_q <= armed_d;
            wcnt_q  <= wcnt_d;
            adr_q   <= ram_adr;
            if (gnt == GNT_CPU) begin
                lane_q <= cpu_adr[0];
                we_q   <= cpu_we;
            end
        end
    end

endmodule
